// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable, coordinates, syncs, active flag and line/frame strobes.
// The generator drives it as master; downstream draw and game-logic stages consume it as slave.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        active;
  logic        line_end;
  logic        frame_end;
  logic [15:0] frame_count;

  modport master (
    output pix_en, h_count, v_count, VGA_HS, VGA_VS, active,
           line_end, frame_end, frame_count
  );

  modport slave (
    input  pix_en, h_count, v_count, VGA_HS, VGA_VS, active,
           line_end, frame_end, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator on CLOCK_50 with an internal 25 MHz pixel enable. Counters are
// registered; syncs, active and strobes decode them with 0-cycle latency. Free-running, no backpressure.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 660,
  parameter int unsigned H_SYNC_END   = 756,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 494,
  parameter int unsigned V_SYNC_END   = 495,
  parameter int unsigned V_TOTAL      = 525
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE   = 10'(H_SYNC_END);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE   = 10'(V_SYNC_END);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  logic        pix_en_q, pix_en_d;
  logic [9:0]  h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        line_end, frame_end;

  always_comb begin
    line_end      = pix_en_q && (h_count_q == H_LAST);
    frame_end     = line_end && (v_count_q == V_LAST);
    pix_en_d      = ~pix_en_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_count_d = frame_count_q;
    // Wrap is compared against the last legal value so counters never reach TOTAL.
    if (pix_en_q) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end
    if (frame_end) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pix_en_q      <= 1'b0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      frame_count_q <= '0;
    end else begin
      pix_en_q      <= pix_en_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.h_count     = h_count_q;
  assign vga.v_count     = v_count_q;
  assign vga.VGA_HS      = ~((h_count_q >= H_SS) && (h_count_q <= H_SE));
  assign vga.VGA_VS      = ~((v_count_q >= V_SS) && (v_count_q <= V_SE));
  assign vga.active      = (h_count_q < H_ACT) && (v_count_q < V_ACT);
  assign vga.line_end    = line_end;
  assign vga.frame_end   = frame_end;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster for reset/line timing, a small raster for frame-level behaviour.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [15:0] fc;
  } st_t;

  typedef struct {
    int ha, hss, hse, ht, va, vss, vse, vt;
  } rast_t;

  logic clk;
  logic rst_f, rst_s;
  int   checks, errors;
  st_t  m_f, m_s;
  st_t  q_f[$];
  st_t  q_s[$];
  rast_t rf, rs;

  vga_timing_gen_if vif_f();
  vga_timing_gen_if vif_s();

  vga_timing_gen dut_f (.CLOCK_50(clk), .reset(rst_f), .vga(vif_f));

  vga_timing_gen #(
    .H_ACTIVE(10), .H_SYNC_START(12), .H_SYNC_END(14), .H_TOTAL(16),
    .V_ACTIVE(6),  .V_SYNC_START(7),  .V_SYNC_END(8),  .V_TOTAL(10)
  ) dut_s (.CLOCK_50(clk), .reset(rst_s), .vga(vif_s));

  logic [41:0] obs_f, obs_s;
  assign obs_f = {vif_f.pix_en, vif_f.h_count, vif_f.v_count, vif_f.VGA_HS, vif_f.VGA_VS,
                  vif_f.active, vif_f.line_end, vif_f.frame_end, vif_f.frame_count};
  assign obs_s = {vif_s.pix_en, vif_s.h_count, vif_s.v_count, vif_s.VGA_HS, vif_s.VGA_VS,
                  vif_s.active, vif_s.line_end, vif_s.frame_end, vif_s.frame_count};

  localparam logic [41:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic st_t step(st_t s, rast_t r, logic rst);
    st_t n;
    if (rst) return '0;
    n     = s;
    n.pix = ~s.pix;
    if (s.pix) begin
      if (int'(s.h) == r.ht - 1) begin
        n.h = '0;
        if (int'(s.v) == r.vt - 1) begin
          n.v  = '0;
          n.fc = s.fc + 16'd1;
        end else begin
          n.v = s.v + 10'd1;
        end
      end else begin
        n.h = s.h + 10'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [41:0] vec(st_t s, rast_t r);
    logic hs, vs, act, le, fe;
    hs  = !(int'(s.h) >= r.hss && int'(s.h) <= r.hse);
    vs  = !(int'(s.v) >= r.vss && int'(s.v) <= r.vse);
    act = (int'(s.h) < r.ha) && (int'(s.v) < r.va);
    le  = s.pix && (int'(s.h) == r.ht - 1);
    fe  = le && (int'(s.v) == r.vt - 1);
    return {s.pix, s.h, s.v, hs, vs, act, le, fe, s.fc};
  endfunction

  task automatic tick_f(input logic r);
    rst_f = r;
    m_f   = step(m_f, rf, r);
    q_f.push_back(m_f);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_s(input logic r);
    rst_s = r;
    m_s   = step(m_s, rs, r);
    q_s.push_back(m_s);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    st_t e;
    int  pix_exp[4] = '{1, 0, 1, 0};
    int  h_exp[4]   = '{0, 1, 1, 2};
    for (int i = 0; i < 3; i++) begin
      tick_f(1'b1);
      e = q_f.pop_front();
      checks++;
      if (obs_f !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %h expected %h", i, obs_f, RESET_VEC);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick_f(1'b0);
      e = q_f.pop_front();
      checks++;
      if (obs_f !== vec(e, rf)) begin
        errors++;
        $display("FAIL release_sb[%0d]: got %h expected %h", i, obs_f, vec(e, rf));
      end
      checks++;
      if (vif_f.pix_en !== 1'(pix_exp[i]) || vif_f.h_count !== 10'(h_exp[i])) begin
        errors++;
        $display("FAIL release_seq[%0d]: got pix=%0b h=%0d expected pix=%0d h=%0d",
                 i, vif_f.pix_en, vif_f.h_count, pix_exp[i], h_exp[i]);
      end
    end
  endtask

  task automatic test_line_timing();
    st_t e;
    int  hs_low = 0, le_cnt = 0, sb_err = 0;
    tick_f(1'b1);
    e = q_f.pop_front();
    for (int i = 0; i < 1600; i++) begin
      tick_f(1'b0);
      e = q_f.pop_front();
      checks++;
      if (obs_f !== vec(e, rf)) begin
        errors++;
        if (sb_err++ < 5) $display("FAIL line_sb[%0d]: got %h expected %h", i, obs_f, vec(e, rf));
      end
      if (vif_f.pix_en && !vif_f.VGA_HS) hs_low++;
      if (vif_f.line_end) le_cnt++;
    end
    checks++;
    if (vif_f.h_count !== 10'd0 || vif_f.v_count !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", vif_f.h_count, vif_f.v_count);
    end
    checks++;
    if (hs_low != 97) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected 97", hs_low);
    end
    checks++;
    if (le_cnt != 1) begin
      errors++;
      $display("FAIL line_end_count: got %0d expected 1", le_cnt);
    end
    rst_f = 1'b1;
  endtask

  task automatic test_frame_timing();
    st_t e;
    int  vs_low = 0, fe_cnt = 0, sb_err = 0;
    logic fe_prev = 1'b0;
    tick_s(1'b1);
    e = q_s.pop_front();
    for (int i = 0; i < 320; i++) begin
      tick_s(1'b0);
      e = q_s.pop_front();
      checks++;
      if (obs_s !== vec(e, rs)) begin
        errors++;
        if (sb_err++ < 5) $display("FAIL frame_sb[%0d]: got %h expected %h", i, obs_s, vec(e, rs));
      end
      if (vif_s.pix_en && !vif_s.VGA_VS) vs_low++;
      if (vif_s.frame_end) begin
        fe_cnt++;
        checks++;
        if (vif_s.h_count !== 10'd15 || vif_s.v_count !== 10'd9) begin
          errors++;
          $display("FAIL frame_end_pos: got h=%0d v=%0d expected h=15 v=9", vif_s.h_count, vif_s.v_count);
        end
      end
      if (fe_prev) begin
        checks++;
        if (vif_s.h_count !== 10'd0 || vif_s.v_count !== 10'd0 || vif_s.frame_count !== 16'd1) begin
          errors++;
          $display("FAIL after_frame_end: got h=%0d v=%0d fc=%0d expected 0 0 1",
                   vif_s.h_count, vif_s.v_count, vif_s.frame_count);
        end
      end
      fe_prev = vif_s.frame_end;
    end
    checks++;
    if (vs_low != 32) begin
      errors++;
      $display("FAIL vsync_width: got %0d expected 32", vs_low);
    end
    checks++;
    if (fe_cnt != 1) begin
      errors++;
      $display("FAIL frame_end_count: got %0d expected 1", fe_cnt);
    end
  endtask

  task automatic test_active_window();
    st_t e;
    int  act_cnt = 0, sb_err = 0;
    for (int i = 0; i < 320; i++) begin
      tick_s(1'b0);
      e = q_s.pop_front();
      checks++;
      if (obs_s !== vec(e, rs)) begin
        errors++;
        if (sb_err++ < 5) $display("FAIL active_sb[%0d]: got %h expected %h", i, obs_s, vec(e, rs));
      end
      if (vif_s.pix_en && vif_s.active) act_cnt++;
      if ((vif_s.h_count == 10'd10 && vif_s.v_count == 10'd0) ||
          (vif_s.h_count == 10'd0 && vif_s.v_count == 10'd6) ||
          (vif_s.h_count == 10'd15 && vif_s.v_count == 10'd9)) begin
        checks++;
        if (vif_s.active !== 1'b0) begin
          errors++;
          $display("FAIL active_corner h=%0d v=%0d: got %0b expected 0",
                   vif_s.h_count, vif_s.v_count, vif_s.active);
        end
      end
    end
    checks++;
    if (act_cnt != 60) begin
      errors++;
      $display("FAIL active_count: got %0d expected 60", act_cnt);
    end
  endtask

  task automatic test_mid_frame_reset();
    st_t e;
    int  strobes = 0, sb_err = 0;
    for (int i = 0; i < 106; i++) begin
      tick_s(1'b0);
      e = q_s.pop_front();
      checks++;
      if (obs_s !== vec(e, rs)) begin
        errors++;
        if (sb_err++ < 5) $display("FAIL midrst_sb[%0d]: got %h expected %h", i, obs_s, vec(e, rs));
      end
    end
    checks++;
    if (vif_s.h_count !== 10'd5 || vif_s.v_count !== 10'd3) begin
      errors++;
      $display("FAIL midrst_pos: got h=%0d v=%0d expected h=5 v=3", vif_s.h_count, vif_s.v_count);
    end
    tick_s(1'b1);
    e = q_s.pop_front();
    checks++;
    if (obs_s !== RESET_VEC) begin
      errors++;
      $display("FAIL midrst_state: got %h expected %h", obs_s, RESET_VEC);
    end
    for (int i = 0; i < 31; i++) begin
      tick_s(1'b0);
      e = q_s.pop_front();
      checks++;
      if (obs_s !== vec(e, rs)) begin
        errors++;
        if (sb_err++ < 5) $display("FAIL postrst_sb[%0d]: got %h expected %h", i, obs_s, vec(e, rs));
      end
      if (i < 30 && (vif_s.line_end || vif_s.frame_end)) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL postrst_strobes: got %0d expected 0", strobes);
    end
    checks++;
    if (vif_s.line_end !== 1'b1 || vif_s.h_count !== 10'd15) begin
      errors++;
      $display("FAIL postrst_line_end: got le=%0b h=%0d expected le=1 h=15", vif_s.line_end, vif_s.h_count);
    end
  endtask

  task automatic test_frame_count_wrap();
    st_t e;
    int  fe_idx = -1, sb_err = 0;
    tick_s(1'b1);
    e = q_s.pop_front();
    for (int i = 0; i < 10; i++) begin
      tick_s(1'b0);
      e = q_s.pop_front();
    end
    force dut_s.frame_count_q = 16'hffff;
    m_s.fc = 16'hffff;
    tick_s(1'b0);
    e = q_s.pop_front();
    release dut_s.frame_count_q;
    for (int i = 0; i < 320; i++) begin
      tick_s(1'b0);
      e = q_s.pop_front();
      checks++;
      if (obs_s !== vec(e, rs)) begin
        errors++;
        if (sb_err++ < 5) $display("FAIL wrap_sb[%0d]: got %h expected %h", i, obs_s, vec(e, rs));
      end
      if (fe_idx < 0 && vif_s.frame_end) begin
        fe_idx = i;
        checks++;
        if (vif_s.frame_count !== 16'hffff) begin
          errors++;
          $display("FAIL wrap_before: got %h expected ffff", vif_s.frame_count);
        end
      end else if (fe_idx >= 0 && i == fe_idx + 1) begin
        checks++;
        if (vif_s.frame_count !== 16'd0) begin
          errors++;
          $display("FAIL wrap_after: got %h expected 0000", vif_s.frame_count);
        end
      end
    end
    checks++;
    if (fe_idx < 0) begin
      errors++;
      $display("FAIL wrap_frame_end: got no frame_end in 320 cycles expected one");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_f  = 1'b1;
    rst_s  = 1'b1;
    m_f    = '0;
    m_s    = '0;
    rf     = '{640, 660, 756, 800, 480, 494, 495, 525};
    rs     = '{10, 12, 14, 16, 6, 7, 8, 10};
    @(negedge clk);
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_active_window();
    test_mid_frame_reset();
    test_frame_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
